// File: rtl/sdram_pixel_reader_pkg.sv
// ----------------------------------------------------------------------------
// sdram_pixel_reader_pkg
//   Shared types and constants for the SDRAM pixel reader: the controller
//   state encoding and the burstcount width derived from the maximum burst.
// ----------------------------------------------------------------------------
package sdram_pixel_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_BURST_LEN = 8;

  // Avalon burstcount must be able to encode BURST_LEN itself, hence +1.
  function automatic int unsigned burst_w(int unsigned burst_len);
    return $clog2(burst_len) + 1;
  endfunction

  localparam int unsigned BURST_W = $clog2(DEF_BURST_LEN) + 1;

endpackage

// File: rtl/sdram_pixel_reader_pixel_rx_fifo.sv
// ----------------------------------------------------------------------------
// pixel_rx_fifo
//   Synchronous first-word-fall-through FIFO holding returned read data until
//   the stream sink accepts it. rdata_o always shows the head word while the
//   FIFO is not empty.
//
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   push_i, wdata_i        : write a word (ignored when full unless popping)
//   pop_i                  : consume the head word (ignored when empty)
//   rdata_o                : head word
//   count_o, full_o, empty_o : occupancy status
// ----------------------------------------------------------------------------
module pixel_rx_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are meaningful, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sdram_pixel_reader.sv
// ----------------------------------------------------------------------------
// sdram_pixel_reader
//   Avalon-MM burst read master that fetches length_words 32-bit pixel words
//   starting at base_addr and streams them, in order, on an Avalon-ST source.
//   Reads are only issued when the receive FIFO is guaranteed room for every
//   word already requested plus the new burst, so returned data never stalls.
//
//   clk_clk, reset_reset_n          : clock, asynchronous active-low reset
//   start, base_addr, length_words  : transfer launch (sampled in IDLE only)
//   busy, done                      : transfer in progress / completion pulse
//   avm_*                           : Avalon-MM read master
//   src_*                           : Avalon-ST source towards the filter
// ----------------------------------------------------------------------------
module sdram_pixel_reader
  import sdram_pixel_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 24,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [LEN_W-1:0]                length_words,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_W-1:0]               avm_address,
  output logic                            avm_read,
  output logic [burst_w(BURST_LEN)-1:0]   avm_burstcount,
  input  logic                            avm_waitrequest,
  input  logic [DATA_W-1:0]               avm_readdata,
  input  logic                            avm_readdatavalid,
  output logic [DATA_W-1:0]               src_data,
  output logic                            src_valid,
  input  logic                            src_ready,
  output logic                            src_endofpacket
);

  localparam int unsigned BW    = burst_w(BURST_LEN);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Headroom for in_flight + fifo count + two bursts without overflow.
  localparam int unsigned OCC_W = LEN_W + 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic [LEN_W-1:0]  in_flight_q, in_flight_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  rem_after;
  logic [BW-1:0]     next_burst;
  logic              accept, push, pop, last_word;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  function automatic logic [BW-1:0] clip_burst(logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(BURST_LEN)) return BW'(BURST_LEN);
    return rem[BW-1:0];
  endfunction

  // `pending` is a burst already accepted this cycle but not yet counted in
  // in_flight_q. Pushes/pops of the current cycle are ignored: a push moves a
  // word from in_flight to the FIFO (net zero) and a pop only frees space, so
  // the check is never optimistic.
  function automatic logic credit_ok(logic [LEN_W-1:0] infl,
                                     logic [CNT_W-1:0] cnt,
                                     logic [BW-1:0]    pending,
                                     logic [BW-1:0]    burst);
    logic [OCC_W-1:0] occ;
    occ = OCC_W'(infl) + OCC_W'(cnt) + OCC_W'(pending) + OCC_W'(burst);
    return occ <= OCC_W'(FIFO_DEPTH);
  endfunction

  assign accept = read_q && !avm_waitrequest;
  // With nothing outstanding any readdatavalid is left over from a transfer
  // abandoned by reset and is dropped.
  assign push   = avm_readdatavalid && (in_flight_q != '0);
  assign pop    = src_valid && src_ready;
  assign last_word = ((out_cnt_q + LEN_W'(1)) == len_q);

  pixel_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .push_i        (push),
    .wdata_i       (avm_readdata),
    .pop_i         (pop),
    .rdata_o       (src_data),
    .count_o       (fifo_count),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    burst_d     = burst_q;
    read_d      = read_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_cnt_d   = pop ? out_cnt_q + LEN_W'(1) : out_cnt_q;
    in_flight_d = in_flight_q + (accept ? LEN_W'(burst_q) : '0)
                              - (push   ? LEN_W'(1)       : '0);
    rem_after   = remaining_q - LEN_W'(burst_q);
    next_burst  = clip_burst(rem_after);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length_words == '0) begin
            done_d = 1'b1;
          end else begin
            // Idle implies nothing outstanding, so the first burst always
            // fits and the read can be raised straight away.
            addr_d      = base_addr;
            remaining_d = length_words;
            len_d       = length_words;
            out_cnt_d   = '0;
            burst_d     = clip_burst(length_words);
            read_d      = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          addr_d      = addr_q + (ADDR_W'(burst_q) << 2);
          remaining_d = rem_after;
          burst_d     = next_burst;
          if (rem_after == '0) begin
            read_d  = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            read_d = credit_ok(in_flight_q, fifo_count, burst_q, next_burst);
          end
        end else if (!read_q) begin
          read_d = credit_ok(in_flight_q, fifo_count, '0, burst_q);
        end
      end
      ST_DRAIN: begin
        // The last word leaving implies nothing in flight and an empty FIFO.
        if (pop && last_word) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= '0;
      burst_q     <= '0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      out_cnt_q   <= out_cnt_d;
      in_flight_q <= in_flight_d;
      burst_q     <= burst_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign avm_address     = addr_q;
  assign avm_read        = read_q;
  assign avm_burstcount  = burst_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign src_valid       = !fifo_empty;
  assign src_endofpacket = src_valid && last_word;

  // The credit rule makes a push into a full FIFO without a pop impossible.
  fifo_no_overflow: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_sdram_pixel_reader.sv
`timescale 1ns/1ps
module tb_sdram_pixel_reader;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] length_words = '0;
  logic        busy, done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_burstcount;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready = 1'b0;
  logic        src_endofpacket;

  sdram_pixel_reader dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .length_words      (length_words),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_endofpacket   (src_endofpacket)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct { logic [31:0] data; logic eop; } word_t;
  typedef struct { logic [31:0] addr; int burst; } cmd_t;

  word_t       exp_q[$];   // expected stream words, in order
  cmd_t        cmd_q[$];   // expected read commands, in order
  logic [31:0] pend_q[$];  // addresses the memory model still owes data for

  int checks = 0;
  int errors = 0;
  int wait_mode = 0;   // 0: never stall, 1: 3 stall cycles per command, 2: random
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random
  int rvalid_mode = 0; // 0: return a word every cycle, 1: random gaps
  int ahead = 0, max_ahead = 0, done_cnt = 0, accepts = 0, reads_seen = 0;

  // SDRAM contents: odd multiplier makes every address map to a distinct word.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(string name, logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected no such event", name, act);
  endtask

  // ---------------- memory slave model ----------------
  initial begin : slave
    int          stall_n;
    logic        prev_stalled;
    logic [31:0] prev_addr;
    logic [3:0]  prev_bc;
    cmd_t        c;
    stall_n = 0;
    prev_stalled = 1'b0;
    prev_addr = '0;
    prev_bc = '0;
    forever begin
      @(posedge clk_clk);
      #2;
      if (pend_q.size() > 0 && (rvalid_mode == 0 || $urandom_range(0, 2) != 0)) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(pend_q.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end
      if (!reset_reset_n) begin
        stall_n = 0;
        prev_stalled = 1'b0;
        avm_waitrequest = 1'b0;
      end else begin
        if (avm_read) reads_seen++;
        if (prev_stalled) begin
          check("stall_read_held", 64'(avm_read), 64'd1);
          check("stall_addr_held", 64'(avm_address), 64'(prev_addr));
          check("stall_bcnt_held", 64'(avm_burstcount), 64'(prev_bc));
        end
        case (wait_mode)
          0: avm_waitrequest = 1'b0;
          1: begin
            if (avm_read && stall_n < 3) begin
              avm_waitrequest = 1'b1;
              stall_n++;
            end else begin
              avm_waitrequest = 1'b0;
              if (avm_read) stall_n = 0;
            end
          end
          default: avm_waitrequest = ($urandom_range(0, 2) == 0);
        endcase
        prev_stalled = avm_read && avm_waitrequest;
        prev_addr    = avm_address;
        prev_bc      = avm_burstcount;
        if (avm_read && !avm_waitrequest) begin
          accepts++;
          if (cmd_q.size() == 0) begin
            flag("unexpected_cmd", 64'(avm_address));
          end else begin
            c = cmd_q.pop_front();
            check("cmd_addr", 64'(avm_address), 64'(c.addr));
            check("cmd_burst", 64'(avm_burstcount), 64'(c.burst));
          end
          for (int i = 0; i < int'(avm_burstcount); i++)
            pend_q.push_back(avm_address + 32'(4 * i));
          ahead += int'(avm_burstcount);
          if (ahead > max_ahead) max_ahead = ahead;
        end
      end
    end
  end

  // ---------------- sink ready driver ----------------
  initial begin : ready_drv
    forever begin
      @(posedge clk_clk);
      #1;
      case (ready_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = 1'b0;
        default: src_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // ---------------- stream monitor / scoreboard ----------------
  initial begin : monitor
    logic  prev_done;
    word_t w;
    prev_done = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (done) begin
        done_cnt++;
        check("done_one_cycle", 64'(prev_done), 64'd0);
      end
      prev_done = done;
      if (src_valid && src_ready) begin
        ahead--;
        if (exp_q.size() == 0) begin
          flag("unexpected_word", 64'(src_data));
        end else begin
          w = exp_q.pop_front();
          check("word_data", 64'(src_data), 64'(w.data));
          check("word_eop", 64'(src_endofpacket), 64'(w.eop));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic launch(logic [31:0] base, int len);
    word_t       w;
    cmd_t        c;
    int          rem;
    logic [31:0] a;
    for (int i = 0; i < len; i++) begin
      w.data = mem_word(base + 32'(4 * i));
      w.eop  = (i == len - 1);
      exp_q.push_back(w);
    end
    rem = len;
    a   = base;
    while (rem > 0) begin
      c.addr  = a;
      c.burst = (rem > 8) ? 8 : rem;
      cmd_q.push_back(c);
      a   = a + 32'(4 * c.burst);
      rem = rem - c.burst;
    end
    @(posedge clk_clk);
    #1;
    start        = 1'b1;
    base_addr    = base;
    length_words = 24'(len);
    @(posedge clk_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk_clk);
      n++;
    end
    repeat (5) @(posedge clk_clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_cmds_left"}, 64'(cmd_q.size()), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals(string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_read"}, 64'(avm_read), 64'd0);
    check({name, "_addr"}, 64'(avm_address), 64'd0);
    check({name, "_bcnt"}, 64'(avm_burstcount), 64'd0);
    check({name, "_valid"}, 64'(src_valid), 64'd0);
    check({name, "_eop"}, 64'(src_endofpacket), 64'd0);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin : stimulus
    int r0, acc0, n;
    logic [31:0] rb;
    repeat (3) @(posedge clk_clk);
    #1;
    check_reset_vals("por");
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;

    // Plain 20-word frame: bursts 8,8,4 at 0x100/0x120/0x140.
    launch(32'h100, 20);
    check("t1_read_latency", 64'(avm_read), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 400);

    // Same frame, each command stalled 3 cycles.
    wait_mode = 1;
    launch(32'h100, 20);
    wait_done("t2", 400);
    wait_mode = 0;

    // Sink blocked: reader may only run FIFO_DEPTH words ahead.
    ready_mode = 1;
    ahead = 0;
    max_ahead = 0;
    launch(32'h4000, 64);
    repeat (100) @(posedge clk_clk);
    #1;
    check("t3_none_delivered", 64'(exp_q.size()), 64'd64);
    check("t3_ahead_le_depth", 64'(max_ahead <= 32), 64'd1);
    check("t3_fwft_head", 64'(src_data), 64'(exp_q[0].data));
    check("t3_valid_held", 64'(src_valid), 64'd1);
    ready_mode = 0;
    wait_done("t3", 600);

    // Zero-length frame: done next cycle, no memory traffic.
    r0 = reads_seen;
    launch(32'h500, 0);
    check("t4_done_latency", 64'(done), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    wait_done("t4", 20);
    check("t4_no_read", 64'(reads_seen - r0), 64'd0);

    // Reset after two bursts; stale returns must be dropped.
    rvalid_mode = 1;
    acc0 = accepts;
    launch(32'h8000, 64);
    n = 0;
    while (accepts - acc0 < 2 && n < 100) begin
      @(posedge clk_clk);
      n++;
    end
    if (accepts - acc0 < 2) flag("t5_accept_timeout", 64'(accepts - acc0));
    #1;
    reset_reset_n = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    #1;
    check_reset_vals("t5_rst");
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    n = 0;
    while (pend_q.size() > 0 && n < 200) begin
      @(posedge clk_clk);
      n++;
    end
    repeat (3) @(posedge clk_clk);
    #1;
    check("t5_stale_drained", 64'(pend_q.size()), 64'd0);
    check("t5_stale_ignored", 64'(src_valid), 64'd0);
    ahead = 0;
    launch(32'h9000, 5);
    wait_done("t5", 200);
    rvalid_mode = 0;

    // Second start while busy must be ignored.
    launch(32'hA000, 12);
    @(posedge clk_clk);
    #1;
    start        = 1'b1;
    base_addr    = 32'hB000;
    length_words = 24'd3;
    @(posedge clk_clk);
    #1;
    start = 1'b0;
    wait_done("t6", 300);
    r0 = reads_seen;
    repeat (10) @(posedge clk_clk);
    #1;
    check("t6_no_second_xfer", 64'(reads_seen - r0), 64'd0);

    // Randomised frames with stalls, gaps and backpressure; first one wraps.
    wait_mode   = 2;
    ready_mode  = 2;
    rvalid_mode = 1;
    for (int k = 0; k < 6; k++) begin
      rb = (k == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      launch(rb, (k == 0) ? 10 : int'($urandom_range(1, 70)));
      wait_done("rnd", 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
